// File: rtl/nibble_serial_alu_if.sv
// Bus bundle for nibble_serial_alu: request side (start/op/operands) driven by
// the master, status/result/lookahead-probe side driven by the ALU.
interface nibble_serial_alu_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = (WIDTH / 4 > 1) ? $clog2(WIDTH / 4) : 1;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic [IDX_W-1:0] nib_idx;
    logic             nib_p_n;
    logic             nib_g_n;

    modport master (
        output start, op, a, b, cin,
        input  ready, busy, done, result, cout, overflow, zero,
        input  nib_idx, nib_p_n, nib_g_n
    );

    modport slave (
        input  start, op, a, b, cin,
        output ready, busy, done, result, cout, overflow, zero,
        output nib_idx, nib_p_n, nib_g_n
    );
endinterface

// File: rtl/nibble_serial_alu.sv
// Nibble-serial ALU: one 4-bit slice reused WIDTH/4 times, least significant
// nibble first, with a single carry flop standing in for the lookahead carry.
// The per-nibble active-low P/G are exported so a lookahead generator model
// can be cross-checked against the serial carry chain.
module nibble_serial_alu #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    nibble_serial_alu_if.slave bus
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_ADC   = 3'b001,
        OP_SUB   = 3'b010,
        OP_SBC   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_PASSB = 3'b111
    } alu_op_e;

    // Control and architecturally visible state (reset)
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Operand capture and partial result (loaded before use)
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    alu_op_e          op_q, op_d;

    // Current-nibble slice signals
    logic       run;
    logic       is_arith;
    logic       invert_b;
    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] bp_nib;
    logic [4:0] sum5;
    logic       grp_p;
    logic       grp_g;
    logic       c_msb_in;
    logic [3:0] nib_res;

    // Carry that seeds nibble 0 for each operation
    function automatic logic init_carry(alu_op_e op, logic cin);
        case (op)
            OP_ADC, OP_SBC: return cin;
            OP_SUB:         return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // 4-bit slice: sum, group propagate/generate, carry into bit 3, logic result
    always_comb begin
        run      = (state_q == S_RUN);
        is_arith = ~op_q[2];
        invert_b = (op_q == OP_SUB) || (op_q == OP_SBC);
        a_nib    = a_q[4*int'(idx_q) +: 4];
        b_nib    = b_q[4*int'(idx_q) +: 4];
        bp_nib   = invert_b ? ~b_nib : b_nib;
        sum5     = {1'b0, a_nib} + {1'b0, bp_nib} + {4'b0000, carry_q};
        grp_p    = &(a_nib | bp_nib);
        grp_g    = ({1'b0, a_nib} + {1'b0, bp_nib}) > 5'd15;
        c_msb_in = ({1'b0, a_nib[2:0]} + {1'b0, bp_nib[2:0]} + {3'b000, carry_q}) > 4'd7;
        case (op_q)
            OP_AND:   nib_res = a_nib & b_nib;
            OP_OR:    nib_res = a_nib | b_nib;
            OP_XOR:   nib_res = a_nib ^ b_nib;
            OP_PASSB: nib_res = b_nib;
            default:  nib_res = sum5[3:0];
        endcase
    end

    // Next-state: FSM transitions, operand capture, nibble write-back, flags
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        op_d     = op_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = alu_op_e'(bus.op);
                    carry_d = init_carry(alu_op_e'(bus.op), bus.cin);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d[4*int'(idx_q) +: 4] = nib_res;
                carry_d = is_arith & sum5[4];
                if (idx_q == LAST_IDX) begin
                    state_d  = S_DONE;
                    idx_d    = '0;
                    result_d = acc_d;
                    cout_d   = is_arith & sum5[4];
                    ovf_d    = is_arith & (c_msb_in ^ sum5[4]);
                    zero_d   = (acc_d == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control/result registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop
            // samples the pre-edge values regardless of statement order.
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Operand and accumulator registers
    // NOTE: no reset on these; they are fully written at every accepted start
    // or during RUN before any visible output depends on them.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        op_q  <= op_d;
    end

    assign bus.ready    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy     = run;
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.nib_idx  = idx_q;
    assign bus.nib_p_n  = ~(run & is_arith & grp_p);
    assign bus.nib_g_n  = ~(run & is_arith & grp_g);

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu (WIDTH=16): hand-computed vectors for
// arithmetic, logic, group P/G, start handling and asynchronous reset.
module tb_nibble_serial_alu;
    localparam int WIDTH = 16;
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADC   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_SBC   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   lat;
    int   bsy;

    nibble_serial_alu_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op_v, input logic [15:0] a_v,
                            input logic [15:0] b_v, input logic cin_v);
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.cin   = cin_v;
        bus.start = 1'b1;
    endtask

    // Count edges until done, checking the old result is held meanwhile
    task automatic wait_done(input logic [15:0] prev_res, output int l, output int b);
        l = 0;
        b = 0;
        while (bus.done !== 1'b1 && l < 20) begin
            if (bus.busy === 1'b1) b++;
            check("held_result", 32'(bus.result), 32'(prev_res));
            tick();
            l++;
        end
        check("done_seen", 32'(bus.done), 1);
    endtask

    task automatic run_op(input logic [2:0] op_v, input logic [15:0] a_v,
                          input logic [15:0] b_v, input logic cin_v,
                          input logic [15:0] prev_res);
        start_op(op_v, a_v, b_v, cin_v);
        tick();
        bus.start = 1'b0;
        wait_done(prev_res, lat, bsy);
        check("latency", lat, 4);
    endtask

    task automatic flags(input string tag, input logic [15:0] res, input logic c,
                         input logic o, input logic z);
        check({tag, "_result"},   32'(bus.result),   32'(res));
        check({tag, "_cout"},     32'(bus.cout),     32'(c));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(o));
        check({tag, "_zero"},     32'(bus.zero),     32'(z));
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.ready),    1);
        check({tag, "_busy"},  32'(bus.busy),     0);
        check({tag, "_done"},  32'(bus.done),     0);
        check({tag, "_idx"},   32'(bus.nib_idx),  0);
        check({tag, "_p_n"},   32'(bus.nib_p_n),  1);
        check({tag, "_g_n"},   32'(bus.nib_g_n),  1);
        flags(tag, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        rst_n     = 1'b1;
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        reset_values("reset");
        rst_n = 1'b1;
        tick();

        // ADD 0x1234 + 0x0FCD = 0x2201; busy 4 cycles, done after edge k+4
        run_op(OP_ADD, 16'h1234, 16'h0FCD, 1'b0, 16'h0000);
        check("add_busy_cycles", bsy, 4);
        check("add_ready_in_done", 32'(bus.ready), 1);
        flags("add", 16'h2201, 1'b0, 1'b0, 1'b0);
        tick();
        check("done_pulse", 32'(bus.done), 0);
        check("idle_ready", 32'(bus.ready), 1);
        check("idle_hold", 32'(bus.result), 32'h2201);

        // Subtraction borrow and exact-zero cases
        run_op(OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'h2201);
        flags("sub_borrow", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op(OP_SUB, 16'h5555, 16'h5555, 1'b0, 16'hFFFF);
        flags("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b1);

        // Signed overflow and carry-in wrap to zero
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h0000);
        flags("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h8000);
        flags("adc_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

        // Group propagate/generate per nibble: 0x000F + 0x0001
        tick();
        check("idle_p_n", 32'(bus.nib_p_n), 1);
        check("idle_g_n", 32'(bus.nib_g_n), 1);
        start_op(OP_ADD, 16'h000F, 16'h0001, 1'b0);
        tick();
        bus.start = 1'b0;
        check("pg_idx0", 32'(bus.nib_idx), 0);
        check("pg_p_n0", 32'(bus.nib_p_n), 0);
        check("pg_g_n0", 32'(bus.nib_g_n), 0);
        tick();
        check("pg_idx1", 32'(bus.nib_idx), 1);
        check("pg_p_n1", 32'(bus.nib_p_n), 1);
        check("pg_g_n1", 32'(bus.nib_g_n), 1);
        wait_done(16'h0000, lat, bsy);
        check("pg_latency", lat, 3);
        flags("pg", 16'h0010, 1'b0, 1'b0, 1'b0);

        // XOR with start held high and operands changed during RUN; the
        // start still high in DONE launches ADD 0x1111 + 0x2222 back-to-back
        start_op(OP_XOR, 16'hF0F0, 16'hFFFF, 1'b0);
        tick();
        bus.op = OP_ADD;
        bus.a  = 16'h1111;
        bus.b  = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            check("held_start_busy", 32'(bus.busy), 1);
            check("held_start_idx", 32'(bus.nib_idx), 32'(i));
            check("logic_p_n", 32'(bus.nib_p_n), 1);
            tick();
        end
        check("xor_done", 32'(bus.done), 1);
        flags("xor", 16'h0F0F, 1'b0, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 1);
        check("b2b_idx", 32'(bus.nib_idx), 0);
        wait_done(16'h0F0F, lat, bsy);
        check("b2b_latency", lat + 1, 5);
        flags("b2b_add", 16'h3333, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN nibble 2
        start_op(OP_ADD, 16'h00FF, 16'h0F01, 1'b0);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_idx", 32'(bus.nib_idx), 2);
        check("pre_rst_busy", 32'(bus.busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        reset_values("mid_rst");
        rst_n = 1'b1;
        run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0000);
        flags("post_rst_add", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Remaining operations
        run_op(OP_PASSB, 16'h1234, 16'hABCD, 1'b1, 16'h0002);
        flags("passb", 16'hABCD, 1'b0, 1'b0, 1'b0);
        run_op(OP_AND, 16'hFF00, 16'h0FF0, 1'b0, 16'hABCD);
        flags("and", 16'h0F00, 1'b0, 1'b0, 1'b0);
        run_op(OP_SBC, 16'h1000, 16'h0001, 1'b0, 16'h0F00);
        flags("sbc", 16'h0FFE, 1'b1, 1'b0, 1'b0);
        run_op(OP_OR, 16'hA000, 16'h0005, 1'b0, 16'h0FFE);
        flags("or", 16'hA005, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
